// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the regfile writeback arbiter.
package rf_wb_pkg;

    localparam int unsigned NUM_GPR   = 32;
    localparam int unsigned REG_ZERO  = 0;
    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_DATA_W = 64;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_EXU  = 2'd1,
        GNT_LSU  = 2'd2
    } wb_gnt_e;

endpackage

// File: rtl/rf_wb_prio_sel.sv
// Two-way writeback selector: LSU first, with an optional EXU anti-starvation
// counter enabled by RF_WB_ARB_STARVE_GUARD_EN.
module rf_wb_prio_sel
    import rf_wb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
`ifdef RF_WB_ARB_STARVE_GUARD_EN
    input  logic clk,
`endif
    input  logic rst,
    input  logic exu_valid,
    input  logic lsu_valid,
    output logic exu_gnt,
    output logic lsu_gnt
);

    if (STARVE_MAX < 1) begin : g_cfg_check
        $error("rf_wb_prio_sel: STARVE_MAX must be at least 1");
    end

    wb_gnt_e gnt;
    logic    force_exu;

`ifdef RF_WB_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign force_exu = (starve_cnt == CNT_W'(STARVE_MAX));

    // Counts consecutive cycles in which a waiting EXU request lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!exu_valid || gnt == GNT_EXU) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    assign force_exu = 1'b0;
`endif

    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (exu_valid && (force_exu || !lsu_valid)) begin
                gnt = GNT_EXU;
            end else if (lsu_valid) begin
                gnt = GNT_LSU;
            end
        end
    end

    assign exu_gnt = (gnt == GNT_EXU);
    assign lsu_gnt = (gnt == GNT_LSU);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Regfile write-port arbiter between EXU and LSU writeback, with pending-write
// scoreboard. Optional EXU starvation guard: RF_WB_ARB_STARVE_GUARD_EN.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exu_valid,
    output logic               exu_ready,
    input  logic [ADDR_W-1:0]  exu_addr,
    input  logic [DATA_W-1:0]  exu_data,
    input  logic               lsu_valid,
    output logic               lsu_ready,
    input  logic [ADDR_W-1:0]  lsu_addr,
    input  logic [DATA_W-1:0]  lsu_data,
    input  logic               issue_set,
    input  logic [ADDR_W-1:0]  issue_rd,
    output logic               rf_wr_en,
    output logic [ADDR_W-1:0]  rf_wr_addr,
    output logic [DATA_W-1:0]  rf_wr_data,
    output logic [NUM_GPR-1:0] pend_mask
);

    logic               exu_gnt;
    logic               lsu_gnt;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               commit;
    logic [NUM_GPR-1:0] set_vec;
    logic [NUM_GPR-1:0] clr_vec;

    rf_wb_prio_sel #(
        .STARVE_MAX(STARVE_MAX)
    ) u_sel (
`ifdef RF_WB_ARB_STARVE_GUARD_EN
        .clk      (clk),
`endif
        .rst      (rst),
        .exu_valid(exu_valid),
        .lsu_valid(lsu_valid),
        .exu_gnt  (exu_gnt),
        .lsu_gnt  (lsu_gnt)
    );

    assign exu_ready = exu_gnt;
    assign lsu_ready = lsu_gnt;

    // A grant to x0 still completes the handshake but never reaches the regfile.
    always_comb begin
        sel_addr = lsu_gnt ? lsu_addr : exu_addr;
        sel_data = lsu_gnt ? lsu_data : exu_data;
        commit   = (exu_gnt || lsu_gnt) && (sel_addr != ADDR_W'(REG_ZERO));
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_set && issue_rd != ADDR_W'(REG_ZERO)) begin
            set_vec[issue_rd] = 1'b1;
        end
        if (commit) begin
            clr_vec[sel_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            pend_mask  <= '0;
        end else begin
            rf_wr_en <= commit;
            if (commit) begin
                rf_wr_addr <= sel_addr;
                rf_wr_data <= sel_data;
            end
            // Set applied after clear: a newly issued producer stays outstanding.
            pend_mask <= (pend_mask & ~clr_vec) | set_vec;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter with a behavioural reference model.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;
    import rf_wb_pkg::*;

    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned STARVE_MAX = 4;
`ifdef RF_WB_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               exu_valid;
    logic               exu_ready;
    logic [ADDR_W-1:0]  exu_addr;
    logic [DATA_W-1:0]  exu_data;
    logic               lsu_valid;
    logic               lsu_ready;
    logic [ADDR_W-1:0]  lsu_addr;
    logic [DATA_W-1:0]  lsu_data;
    logic               issue_set;
    logic [ADDR_W-1:0]  issue_rd;
    logic               rf_wr_en;
    logic [ADDR_W-1:0]  rf_wr_addr;
    logic [DATA_W-1:0]  rf_wr_data;
    logic [NUM_GPR-1:0] pend_mask;

    rf_wb_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .exu_valid (exu_valid),
        .exu_ready (exu_ready),
        .exu_addr  (exu_addr),
        .exu_data  (exu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_addr  (lsu_addr),
        .lsu_data  (lsu_data),
        .issue_set (issue_set),
        .issue_rd  (issue_rd),
        .rf_wr_en  (rf_wr_en),
        .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data),
        .pend_mask (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                 n_checks = 0;
    int                 n_fail   = 0;
    wb_req_t            exp_q[$];
    logic [NUM_GPR-1:0] pend_model = '0;
    wb_req_t            last_model = '0;
    int unsigned        exu_losses = 0;
    bit                 exu_acc = 1'b0;
    bit                 lsu_acc = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: evaluates each cycle's handshake mid-cycle and predicts the next edge.
    always @(negedge clk) begin
        bit      ew;
        bit      lw;
        wb_req_t w;
        exu_acc = 1'b0;
        lsu_acc = 1'b0;
        if (rst) begin
            check("rst_exu_ready", 64'(exu_ready), 64'd0);
            check("rst_lsu_ready", 64'(lsu_ready), 64'd0);
            pend_model = '0;
            last_model = '0;
            exu_losses = 0;
        end else begin
            ew = exu_valid && (!lsu_valid || (GUARD && exu_losses == STARVE_MAX));
            lw = lsu_valid && !ew;
            check("exu_ready", 64'(exu_ready), 64'(ew));
            check("lsu_ready", 64'(lsu_ready), 64'(lw));
            exu_acc = ew;
            lsu_acc = lw;
            exu_losses = (exu_valid && !ew) ? exu_losses + 1 : 0;
            if (ew || lw) begin
                w.addr = lw ? lsu_addr : exu_addr;
                w.data = lw ? lsu_data : exu_data;
                if (w.addr != 0) begin
                    exp_q.push_back(w);
                    last_model = w;
                    pend_model[w.addr] = 1'b0;
                end
            end
            if (issue_set && issue_rd != 0) pend_model[issue_rd] = 1'b1;
        end
    end

    // Monitor: compares the registered write port and scoreboard after each edge.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            wb_req_t e;
            e = exp_q.pop_front();
            check("wr_en", 64'(rf_wr_en), 64'd1);
            check("wr_addr", 64'(rf_wr_addr), 64'(e.addr));
            check("wr_data", rf_wr_data, e.data);
        end else begin
            check("wr_en_idle", 64'(rf_wr_en), 64'd0);
        end
        check("wr_addr_hold", 64'(rf_wr_addr), 64'(last_model.addr));
        check("wr_data_hold", rf_wr_data, last_model.data);
        check("pend_mask", 64'(pend_mask), 64'(pend_model));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exu(input bit v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exu_valid = v;
        exu_addr  = a;
        exu_data  = d;
    endtask

    task automatic set_lsu(input bit v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        lsu_valid = v;
        lsu_addr  = a;
        lsu_data  = d;
    endtask

    task automatic set_issue(input bit v, input logic [ADDR_W-1:0] rd);
        issue_set = v;
        issue_rd  = rd;
    endtask

    initial begin
        rst = 1'b1;
        set_exu(1'b1, 5'd1, 64'h11);
        set_lsu(1'b1, 5'd2, 64'h22);
        set_issue(1'b1, 5'd4);
        tick();
        tick();

        rst = 1'b0;
        set_lsu(1'b0, 5'd0, 64'h0);
        set_issue(1'b0, 5'd0);
        set_exu(1'b1, 5'd5, 64'hDEAD);
        tick();
        set_exu(1'b0, 5'd0, 64'h0);
        tick();

        set_exu(1'b1, 5'd3, 64'h333);
        set_lsu(1'b1, 5'd7, 64'h777);
        tick();
        set_lsu(1'b0, 5'd0, 64'h0);
        tick();
        set_exu(1'b0, 5'd0, 64'h0);
        tick();

        set_issue(1'b1, 5'd12);
        tick();
        set_issue(1'b0, 5'd0);
        set_lsu(1'b1, 5'd0, 64'h55);
        tick();
        set_lsu(1'b0, 5'd0, 64'h0);
        tick();

        set_issue(1'b1, 5'd9);
        tick();
        set_issue(1'b1, 5'd9);
        set_exu(1'b1, 5'd9, 64'h999);
        tick();
        set_issue(1'b0, 5'd0);
        set_exu(1'b0, 5'd0, 64'h0);
        tick();
        set_exu(1'b1, 5'd9, 64'h9A9);
        tick();
        set_exu(1'b0, 5'd0, 64'h0);
        tick();

        set_exu(1'b1, 5'd11, 64'hE0);
        for (int i = 0; i < 15; i++) begin
            set_lsu(1'b1, 5'($urandom_range(1, 31)), {$urandom, $urandom});
            tick();
            if (exu_acc) set_exu(1'b1, 5'd11, {$urandom, $urandom});
        end
        set_exu(1'b0, 5'd0, 64'h0);
        set_lsu(1'b0, 5'd0, 64'h0);
        tick();

        for (int i = 0; i < 600; i++) begin
            if (!exu_valid || exu_acc)
                set_exu($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), {$urandom, $urandom});
            if (!lsu_valid || lsu_acc)
                set_lsu($urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), {$urandom, $urandom});
            set_issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end

        rst = 1'b0;
        set_exu(1'b0, 5'd0, 64'h0);
        set_lsu(1'b0, 5'd0, 64'h0);
        set_issue(1'b0, 5'd0);
        tick();
        tick();
        tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
